// File: rtl/tl_pkg.sv
// tl_pkg: shared codes, state encoding and default durations for the light interval timer.
package tl_pkg;

    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;
    localparam logic [1:0] INT_DBL  = 2'b11;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;

    localparam logic [3:0] DEF_BASE = 4'd6;
    localparam logic [3:0] DEF_EXT  = 4'd3;
    localparam logic [3:0] DEF_YEL  = 4'd2;

    typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler; tick marks the last count, one_hz is its registered pulse.
module tick_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic one_hz
);
    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(CLK_DIV - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt    <= '0;
            one_hz <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            one_hz <= tick;
        end
    end
endmodule

// File: rtl/light_interval_timer.sv
// light_interval_timer: reprogrammable duration store and one-shot second countdown
// that pulses expired when the requested interval has elapsed.
module light_interval_timer
    import tl_pkg::*;
#(
    parameter int         CLK_DIV    = 10,
    parameter logic [3:0] T_BASE_DEF = DEF_BASE,
    parameter logic [3:0] T_EXT_DEF  = DEF_EXT,
    parameter logic [3:0] T_YEL_DEF  = DEF_YEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reprogram,
    input  logic [1:0] tp_sel,
    input  logic [3:0] t_val,
    input  logic       start,
    input  logic [1:0] interval,
    output logic       busy,
    output logic       expired,
    output logic [4:0] remaining,
    output logic       one_hz
);
    logic [3:0] base, ext, yel, wr_val;
    logic [4:0] len;
    logic       tick, last;
    state_t     state, state_next;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .tick   (tick),
        .one_hz (one_hz)
    );

    // A stored zero would never expire, so it is clamped to one second.
    assign wr_val = (t_val == 4'd0) ? 4'd1 : t_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            base <= T_BASE_DEF;
            ext  <= T_EXT_DEF;
            yel  <= T_YEL_DEF;
        end else if (reprogram) begin
            if (tp_sel == SEL_BASE) base <= wr_val;
            if (tp_sel == SEL_EXT)  ext  <= wr_val;
            if (tp_sel == SEL_YEL)  yel  <= wr_val;
        end
    end

    always_comb begin
        len = (interval == INT_DBL) ? {base, 1'b0} :
              {1'b0, (interval == INT_EXT) ? ext : (interval == INT_YEL) ? yel : base};
    end

    assign last = (state == RUN) && tick && (remaining == 5'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // start always wins, so a restart on the terminal tick keeps running.
    always_comb begin
        state_next = start ? RUN : last ? IDLE : state;
    end

    always_comb begin
        busy = state == RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= 5'd0;
            expired   <= 1'b0;
        end else begin
            expired <= last && !start;
            if (start)
                remaining <= len;
            else if (state == RUN && tick)
                remaining <= remaining - 5'd1;
        end
    end
endmodule

// File: tb/tb_light_interval_timer.sv
// tb_light_interval_timer: directed checks of timing, reprogramming, restart and reset behaviour.
module tb_light_interval_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reprogram = 1'b0;
    logic [1:0] tp_sel = 2'b00;
    logic [3:0] t_val = 4'd0;
    logic       start = 1'b0;
    logic [1:0] interval = 2'b00;
    logic       busy, expired, one_hz;
    logic [4:0] remaining;

    int vec = 0;
    int miss = 0;
    int n;

    light_interval_timer #(.CLK_DIV(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .reprogram (reprogram),
        .tp_sel    (tp_sel),
        .t_val     (t_val),
        .start     (start),
        .interval  (interval),
        .busy      (busy),
        .expired   (expired),
        .remaining (remaining),
        .one_hz    (one_hz)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles from the start edge until expired is seen, bounded at 400.
    task automatic wait_exp(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!expired && cnt < 400);
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] val);
        reprogram = 1'b1;
        tp_sel = sel;
        t_val = val;
        step();
        reprogram = 1'b0;
    endtask

    task automatic kick(input logic [1:0] iv);
        start = 1'b1;
        interval = iv;
        step();
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] iv, input int exp_cycles);
        int c;
        kick(iv);
        chk({tag, "_busy"}, int'(busy), 1);
        wait_exp(c);
        chk({tag, "_latency"}, c, exp_cycles);
        step();
        chk({tag, "_pulse_width"}, int'(expired), 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_rem"}, int'(remaining), 0);
    endtask

    initial begin
        int last_hz, pulses;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_expired", int'(expired), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_one_hz", int'(one_hz), 0);

        kick(2'b00);
        chk("base_busy", int'(busy), 1);
        for (int k = 0; k < 6; k++) begin
            chk("base_rem_step", int'(remaining), 6 - k);
            chk("base_no_early_exp", int'(expired), 0);
            if (k < 5) repeat (10) step();
        end
        wait_exp(n);
        chk("base_latency_tail", n, 10);
        chk("base_rem_at_exp", int'(remaining), 0);
        step();
        chk("base_pulse_width", int'(expired), 0);
        chk("base_rem_after", int'(remaining), 0);

        prog(2'b10, 4'd5);
        run("yel5", 2'b10, 50);
        prog(2'b11, 4'd9);
        run("ext_unchanged", 2'b01, 30);
        run("base_unchanged", 2'b00, 60);
        run("yel_unchanged", 2'b10, 50);

        prog(2'b00, 4'd0);
        run("base_zero_clamp", 2'b00, 10);
        prog(2'b00, 4'd15);
        kick(2'b11);
        chk("dbl_load", int'(remaining), 30);
        wait_exp(n);
        chk("dbl_latency", n, 300);

        prog(2'b00, 4'd6);
        kick(2'b00);
        repeat (24) step();
        chk("restart_no_exp", int'(expired), 0);
        kick(2'b00);
        chk("restart_reload", int'(remaining), 6);
        wait_exp(n);
        chk("restart_latency", n, 60);

        kick(2'b00);
        repeat (59) step();
        chk("term_rem_one", int'(remaining), 1);
        kick(2'b00);
        chk("term_suppressed", int'(expired), 0);
        chk("term_reload", int'(remaining), 6);
        chk("term_busy", int'(busy), 1);
        wait_exp(n);
        chk("term_latency", n, 60);

        prog(2'b00, 4'd9);
        kick(2'b00);
        chk("abort_load", int'(remaining), 9);
        repeat (29) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rem", int'(remaining), 0);
        chk("abort_exp", int'(expired), 0);
        run("base_default_restored", 2'b00, 60);

        last_hz = -1;
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            step();
            if (one_hz) begin
                if (last_hz >= 0) chk("one_hz_period", i - last_hz, 10);
                last_hz = i;
                pulses++;
            end
        end
        chk("one_hz_count", pulses, 3);

        reprogram = 1'b1;
        tp_sel = 2'b00;
        t_val = 4'd3;
        kick(2'b00);
        reprogram = 1'b0;
        chk("same_cycle_old_len", int'(remaining), 6);
        wait_exp(n);
        chk("same_cycle_latency", n, 60);
        step();
        run("same_cycle_new_len", 2'b00, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
